// File: rtl/load_store_unit.sv
// load_store_unit: M-stage load/store unit for the RV32I pipeline.
// Runs one req/ack data-bus transaction per M-stage access and stalls the
// pipeline until it finishes. Load data is aligned, extended and held in
// ReadDataW until the next load completes.
// Optional feature: define LSU_MISALIGN_TRAP_EN to fault misaligned H/W
// accesses without a bus transaction.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   MemReadM/MemWriteM          load/store request (both high -> store)
//   funct3M, ALUResultM         access size/sign and byte address
//   WriteDataM                  store data
//   StallLSU                    pipeline freeze (combinational)
//   ReadDataW, LSUFaultW        registered load data and one-cycle fault
//   mem_req/we/addr/wdata/wstrb registered bus request
//   mem_ack/rdata/err           bus response
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        StallLSU,
  output logic [31:0] ReadDataW,
  output logic        LSUFaultW,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err
);

  localparam int unsigned CntW = 8;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic [31:0]     rdw_q, rdw_d;
  logic            fault_q, fault_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      lo_q, lo_d;

  logic            access_c;
  logic            misalign_c;
  logic [31:0]     st_wdata_c;
  logic [3:0]      st_wstrb_c;
  logic [7:0]      ld_byte_c;
  logic [15:0]     ld_half_c;
  logic [31:0]     ld_ext_c;

  assign access_c = MemReadM | MemWriteM;

  // Misaligned halfword (a[0]) or word (a[1:0]) access; funct3 x1x is word.
`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_c = ((funct3M[1:0] == 2'b01) && ALUResultM[0]) ||
                      (funct3M[1] && (ALUResultM[1:0] != 2'b00));
`else
  assign misalign_c = 1'b0;
`endif

  // Freeze the pipeline from the access cycle until DONE; reset releases it at once.
  assign StallLSU = rst_n && (((state_q == S_IDLE) && access_c) || (state_q == S_REQ));

  // Store lane replication and byte enables.
  always_comb begin
    st_wdata_c = WriteDataM;
    st_wstrb_c = 4'hF;
    case (funct3M[1:0])
      2'b00: begin
        st_wdata_c = {4{WriteDataM[7:0]}};
        st_wstrb_c = 4'b0001 << ALUResultM[1:0];
      end
      2'b01: begin
        st_wdata_c = {2{WriteDataM[15:0]}};
        st_wstrb_c = 4'b0011 << {ALUResultM[1], 1'b0};
      end
      default: ;
    endcase
  end

  // Load lane extraction and sign/zero extension from the latched access info.
  always_comb begin
    case (lo_q)
      2'b00:   ld_byte_c = mem_rdata[7:0];
      2'b01:   ld_byte_c = mem_rdata[15:8];
      2'b10:   ld_byte_c = mem_rdata[23:16];
      default: ld_byte_c = mem_rdata[31:24];
    endcase
    ld_half_c = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q[1:0])
      2'b00:   ld_ext_c = f3_q[2] ? {24'h0, ld_byte_c} : {{24{ld_byte_c[7]}}, ld_byte_c};
      2'b01:   ld_ext_c = f3_q[2] ? {16'h0, ld_half_c} : {{16{ld_half_c[15]}}, ld_half_c};
      default: ld_ext_c = mem_rdata;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdw_d   = rdw_q;
    fault_d = fault_q;
    f3_d    = f3_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (access_c) begin
          if (misalign_c) begin
            state_d = S_DONE;
            fault_d = 1'b1;
            if (!MemWriteM) rdw_d = 32'h0;
          end else begin
            state_d = S_REQ;
            req_d   = 1'b1;
            cnt_d   = '0;
            we_d    = MemWriteM;
            addr_d  = {ALUResultM[31:2], 2'b00};
            wdata_d = st_wdata_c;
            wstrb_d = MemWriteM ? st_wstrb_c : 4'h0;
            f3_d    = funct3M;
            lo_d    = ALUResultM[1:0];
          end
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          fault_d = mem_err;
          if (!we_q) rdw_d = mem_err ? 32'h0 : ld_ext_c;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        fault_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
        fault_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'h0;
      rdw_q   <= 32'h0;
      fault_q <= 1'b0;
      f3_q    <= 3'b000;
      lo_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdw_q   <= rdw_d;
      fault_q <= fault_d;
      f3_q    <= f3_d;
      lo_q    <= lo_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign ReadDataW = rdw_q;
  assign LSUFaultW = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit (TIMEOUT = 4).
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemReadM, MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic        StallLSU;
  logic [31:0] ReadDataW;
  logic        LSUFaultW;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata;
  logic        mem_err;

  int checks = 0;
  int errors = 0;

  int bus_wait  = 0;
  bit bus_noack = 1'b0;
  bit bus_force = 1'b0;
  int wcnt      = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .funct3M(funct3M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .StallLSU(StallLSU), .ReadDataW(ReadDataW), .LSUFaultW(LSUFaultW),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  // Bus responder: ack after bus_wait request cycles, or never when bus_noack.
  always @(negedge clk) begin
    if (bus_force) begin
      mem_ack = 1'b1;
    end else if (!mem_req || mem_ack) begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end else begin
      if (!bus_noack && wcnt == bus_wait) mem_ack = 1'b1;
      wcnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rdata;
    int          wt;
    bit          noack, err;
    int          stalls, reqcyc;
    logic [31:0] baddr, bwdata, rdw;
    logic [3:0]  strb;
    logic        fault;
  } vec_t;

  typedef struct {
    int          stalls, reqcyc;
    logic [31:0] baddr, bwdata, rdw;
    logic [3:0]  strb;
    logic        we, fault;
  } res_t;

  res_t exp_q[$];

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int wt, input bit noack,
                              input bit err, input int stalls, input int reqcyc,
                              input logic [31:0] baddr, input logic [3:0] strb,
                              input logic [31:0] bwdata, input logic [31:0] rdw,
                              input logic fault);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.wt = wt; v.noack = noack; v.err = err; v.stalls = stalls; v.reqcyc = reqcyc;
    v.baddr = baddr; v.strb = strb; v.bwdata = bwdata; v.rdw = rdw; v.fault = fault;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    res_t e, a;
    bit   seen, done;
    e.stalls = v.stalls; e.reqcyc = v.reqcyc; e.baddr = v.baddr; e.bwdata = v.bwdata;
    e.rdw = v.rdw; e.strb = v.strb; e.we = v.wr; e.fault = v.fault;
    exp_q.push_back(e);
    a = '{default: '0};
    seen = 1'b0;
    done = 1'b0;
    @(negedge clk);
    bus_wait = v.wt; bus_noack = v.noack; mem_rdata = v.rdata; mem_err = v.err;
    funct3M = v.f3; ALUResultM = v.addr; WriteDataM = v.wdata;
    MemReadM = v.rd; MemWriteM = v.wr;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (mem_req) begin
        if (!seen) begin
          a.baddr = mem_addr; a.bwdata = mem_wdata; a.strb = mem_wstrb; a.we = mem_we;
        end else if (mem_addr !== a.baddr || mem_wstrb !== a.strb || mem_we !== a.we) begin
          chk($sformatf("v%0d_bus_stable", idx), {mem_addr[31:4], mem_wstrb}, {a.baddr[31:4], a.strb});
        end
        seen = 1'b1;
        a.reqcyc++;
      end
      if (!StallLSU) begin
        done = 1'b1;
        break;
      end
      a.stalls++;
      @(negedge clk);
    end
    if (!done) chk($sformatf("v%0d_stall_bound", idx), 32'd0, 32'd1);
    a.fault = LSUFaultW;
    MemReadM = 1'b0; MemWriteM = 1'b0;
    @(posedge clk); #1;
    a.rdw = ReadDataW;
    chk($sformatf("v%0d_fault_one_cycle", idx), {31'h0, LSUFaultW}, 32'h0);
    e = exp_q.pop_front();
    chk($sformatf("v%0d_stalls", idx), a.stalls, e.stalls);
    chk($sformatf("v%0d_req_cycles", idx), a.reqcyc, e.reqcyc);
    chk($sformatf("v%0d_fault", idx), {31'h0, a.fault}, {31'h0, e.fault});
    chk($sformatf("v%0d_readdataw", idx), a.rdw, e.rdw);
    if (e.reqcyc > 0) begin
      chk($sformatf("v%0d_mem_addr", idx), a.baddr, e.baddr);
      chk($sformatf("v%0d_mem_we", idx), {31'h0, a.we}, {31'h0, e.we});
      chk($sformatf("v%0d_mem_wstrb", idx), {28'h0, a.strb}, {28'h0, e.strb});
      if (e.we) chk($sformatf("v%0d_mem_wdata", idx), a.bwdata, e.bwdata);
    end
  endtask

  vec_t tbl[11];

  initial begin
    // rd wr f3 addr wdata rdata wait noack err | stalls reqcyc baddr strb bwdata rdw fault
    tbl[0] = mk(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 0, 0, 0, 2, 1, 32'h100, 4'h0, 32'h0, 32'hFFFF_FF80, 0);
    tbl[1] = mk(1, 0, 3'b101, 32'h102, 32'h0, 32'h80FF_1234, 3, 0, 0, 5, 4, 32'h100, 4'h0, 32'h0, 32'h0000_80FF, 0);
    tbl[2] = mk(0, 1, 3'b000, 32'h101, 32'hAABB_CCDD, 32'h0, 0, 0, 0, 2, 1, 32'h100, 4'b0010, 32'hDDDD_DDDD, 32'h0000_80FF, 0);
    tbl[3] = mk(1, 0, 3'b010, 32'h200, 32'h0, 32'h1234_5678, 1, 0, 1, 3, 2, 32'h200, 4'h0, 32'h0, 32'h0, 1);
    tbl[4] = mk(1, 0, 3'b010, 32'h204, 32'h0, 32'h0, 0, 1, 0, 5, 4, 32'h204, 4'h0, 32'h0, 32'h0, 1);
    tbl[5] = mk(1, 0, 3'b001, 32'h100, 32'h0, 32'h1234_8001, 0, 0, 0, 2, 1, 32'h100, 4'h0, 32'h0, 32'hFFFF_8001, 0);
    tbl[6] = mk(0, 1, 3'b001, 32'h102, 32'h1111_BEEF, 32'h0, 2, 0, 0, 4, 3, 32'h100, 4'b1100, 32'hBEEF_BEEF, 32'hFFFF_8001, 0);
    tbl[7] = mk(1, 0, 3'b100, 32'h101, 32'h0, 32'h80FF_1234, 0, 0, 0, 2, 1, 32'h100, 4'h0, 32'h0, 32'h0000_0012, 0);
    tbl[8] = mk(1, 1, 3'b010, 32'h104, 32'h1234_5678, 32'hFFFF_FFFF, 0, 0, 0, 2, 1, 32'h104, 4'hF, 32'h1234_5678, 32'h0000_0012, 0);
    tbl[9] = mk(1, 0, 3'b011, 32'h108, 32'h0, 32'hCAFE_BABE, 0, 0, 0, 2, 1, 32'h108, 4'h0, 32'h0, 32'hCAFE_BABE, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    tbl[10] = mk(1, 0, 3'b010, 32'h102, 32'h0, 32'h80FF_1234, 0, 0, 0, 1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 1);
`else
    tbl[10] = mk(1, 0, 3'b010, 32'h102, 32'h0, 32'h80FF_1234, 0, 0, 0, 2, 1, 32'h100, 4'h0, 32'h0, 32'h80FF_1234, 0);
`endif

    rst_n = 1'b0;
    MemReadM = 1'b0; MemWriteM = 1'b0; funct3M = 3'b000;
    ALUResultM = 32'h0; WriteDataM = 32'h0; mem_rdata = 32'h0; mem_err = 1'b0;
    #12;
    chk("rst_readdataw", ReadDataW, 32'h0);
    chk("rst_fault", {31'h0, LSUFaultW}, 32'h0);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
    chk("rst_stall", {31'h0, StallLSU}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(tbl[i], i);

    // An ack while idle must not start or complete anything.
    @(negedge clk);
    bus_force = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("idle_ack_req", {31'h0, mem_req}, 32'h0);
    chk("idle_ack_stall", {31'h0, StallLSU}, 32'h0);
    chk("idle_ack_fault", {31'h0, LSUFaultW}, 32'h0);
    chk("idle_ack_rdw", ReadDataW, 32'h0);
    bus_force = 1'b0;

    for (int i = 5; i < 11; i++) run_vec(tbl[i], i);

    // Reset in the middle of a request drops req and stall at once.
    @(negedge clk);
    bus_noack = 1'b1; funct3M = 3'b010; ALUResultM = 32'h300; MemReadM = 1'b1;
    @(negedge clk); #1;
    chk("midrst_req_before", {31'h0, mem_req}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midrst_req", {31'h0, mem_req}, 32'h0);
    chk("midrst_stall", {31'h0, StallLSU}, 32'h0);
    chk("midrst_rdw", ReadDataW, 32'h0);
    MemReadM = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; bus_noack = 1'b0;
    @(negedge clk); #1;
    chk("postrst_req", {31'h0, mem_req}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
